// File: rtl/norz_flipflop_pkg.sv
// Shared definitions for the I flipflop word register: default width and state encoding.
package norz_flipflop_pkg;

    localparam int unsigned I_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        FULL_PEND = 2'd2
    } i_state_e;

endpackage

// File: rtl/flipflop_i_slot.sv
// One word of storage for the I register: async reset, load enable, synchronous clear.
module flipflop_i_slot
    import norz_flipflop_pkg::*;
#(
    parameter int unsigned W = I_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] word_q;
    logic [W-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (clr) begin
            word_d = '0;
        end else if (en) begin
            word_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign q = word_q;

endmodule

// File: rtl/flipflop_i_reg.sv
// I flipflop word register with handshake and sticky overrun.
// Define FLIPFLOP_I_PEND_EN to add a second (pending) slot so a load can land while full.
module flipflop_i_reg
    import norz_flipflop_pkg::*;
#(
    parameter int unsigned I_WIDTH = I_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               phase_p2,
    input  logic               set_any,
    input  logic [I_WIDTH-1:0] encoded,
    input  logic               i_ack,
    input  logic               i_clear,
    output logic [I_WIDTH-1:0] i_q,
    output logic               i_valid,
    output logic               i_ready,
    output logic               overrun
);

    i_state_e state_q;
    i_state_e state_d;

    logic               load_c;
    logic               ready_c;
    logic               accept_c;
    logic               drop_c;
    logic               iq_en_c;
    logic [I_WIDTH-1:0] iq_din_c;
    logic               valid_q;
    logic               valid_d;
    logic               overrun_q;
    logic               overrun_d;

`ifdef FLIPFLOP_I_PEND_EN
    logic               pend_en_c;
    logic [I_WIDTH-1:0] pend_q;
`endif

    // A strobe outside P2 is not a load at all, so it can never count as an overrun.
    assign load_c = phase_p2 & set_any;

`ifdef FLIPFLOP_I_PEND_EN
    assign ready_c = (state_q != FULL_PEND) | i_ack;
`else
    assign ready_c = (state_q == EMPTY) | i_ack;
`endif

    assign accept_c = load_c & ready_c;
    assign drop_c   = load_c & ~ready_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush wins over everything
    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept_c) begin
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (i_ack) begin
                        state_d = accept_c ? FULL : EMPTY;
`ifdef FLIPFLOP_I_PEND_EN
                    end else if (accept_c) begin
                        state_d = FULL_PEND;
`endif
                    end
                end
`ifdef FLIPFLOP_I_PEND_EN
                FULL_PEND: begin
                    if (i_ack) begin
                        state_d = accept_c ? FULL_PEND : FULL;
                    end
                end
`endif
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Slot steering: which word lands in i_q / pend this cycle
    always_comb begin
        iq_en_c  = 1'b0;
        iq_din_c = encoded;
`ifdef FLIPFLOP_I_PEND_EN
        pend_en_c = 1'b0;
`endif
        case (state_q)
            EMPTY: begin
                iq_en_c = accept_c;
            end
            FULL: begin
                iq_en_c = i_ack & accept_c;
`ifdef FLIPFLOP_I_PEND_EN
                pend_en_c = ~i_ack & accept_c;
`endif
            end
`ifdef FLIPFLOP_I_PEND_EN
            FULL_PEND: begin
                iq_en_c   = i_ack;
                iq_din_c  = pend_q;
                pend_en_c = accept_c;
            end
`endif
            default: begin
                iq_en_c = 1'b0;
            end
        endcase
    end

    assign valid_d   = (state_d != EMPTY);
    assign overrun_d = i_clear ? 1'b0 : (overrun_q | drop_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    flipflop_i_slot #(
        .W (I_WIDTH)
    ) u_slot_i (
        .clk (clk),
        .rst (rst),
        .en  (iq_en_c),
        .clr (i_clear),
        .d   (iq_din_c),
        .q   (i_q)
    );

`ifdef FLIPFLOP_I_PEND_EN
    flipflop_i_slot #(
        .W (I_WIDTH)
    ) u_slot_pend (
        .clk (clk),
        .rst (rst),
        .en  (pend_en_c),
        .clr (i_clear),
        .d   (encoded),
        .q   (pend_q)
    );
`endif

    assign i_valid = valid_q;
    assign i_ready = ready_c;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_flipflop_i_reg.sv
// Self-checking bench for flipflop_i_reg: directed table, corner sequences, random vs queue model.
module tb_flipflop_i_reg;

`ifdef FLIPFLOP_I_PEND_EN
    localparam bit PEND = 1'b1;
`else
    localparam bit PEND = 1'b0;
`endif
    localparam int unsigned CAP = PEND ? 2 : 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       phase_p2 = 1'b0;
    logic       set_any = 1'b0;
    logic [7:0] encoded = 8'h00;
    logic       i_ack = 1'b0;
    logic       i_clear = 1'b0;
    logic [7:0] i_q;
    logic       i_valid;
    logic       i_ready;
    logic       overrun;

    int n_vec  = 0;
    int n_miss = 0;

    flipflop_i_reg #(.I_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .phase_p2 (phase_p2),
        .set_any  (set_any),
        .encoded  (encoded),
        .i_ack    (i_ack),
        .i_clear  (i_clear),
        .i_q      (i_q),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Reference: a FIFO of at most CAP words; i_q shows the head, or the last head once drained.
    logic [7:0] m_fifo[$];
    logic [7:0] m_shown = 8'h00;
    bit         m_ovr   = 1'b0;

    function automatic bit model_ready(bit ack);
        return (m_fifo.size() < CAP) || ack;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_shown = 8'h00;
        m_ovr   = 1'b0;
    endtask

    task automatic model_step(bit load, logic [7:0] e, bit ack, bit clr);
        bit rdy;
        if (clr) begin
            model_reset();
        end else begin
            rdy = model_ready(ack);
            if (ack && m_fifo.size() > 0) void'(m_fifo.pop_front());
            if (load) begin
                if (rdy) m_fifo.push_back(e);
                else     m_ovr = 1'b1;
            end
            if (m_fifo.size() > 0) m_shown = m_fifo[0];
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; always checked against the model, optionally against fixed values.
    task automatic vec(string name, bit p, bit s, logic [7:0] e, bit a, bit c,
                       bit use_exp, bit er, logic [7:0] eq, bit ev, bit eo);
        @(negedge clk);
        phase_p2 = p; set_any = s; encoded = e; i_ack = a; i_clear = c;
        #1;
        chk({name, ".ready(model)"}, 32'(i_ready), 32'(model_ready(a)));
        if (use_exp) chk({name, ".ready"}, 32'(i_ready), 32'(er));
        @(posedge clk);
        #1;
        model_step(p & s, e, a, c);
        chk({name, ".i_q(model)"},     32'(i_q),     32'(m_shown));
        chk({name, ".i_valid(model)"}, 32'(i_valid), 32'(m_fifo.size() > 0));
        chk({name, ".overrun(model)"}, 32'(overrun), 32'(m_ovr));
        if (use_exp) begin
            chk({name, ".i_q"},     32'(i_q),     32'(eq));
            chk({name, ".i_valid"}, 32'(i_valid), 32'(ev));
            chk({name, ".overrun"}, 32'(overrun), 32'(eo));
        end
    endtask

    task automatic check_reset_vals(string name);
        chk({name, ".i_q"},     32'(i_q),     32'h0);
        chk({name, ".i_valid"}, 32'(i_valid), 32'h0);
        chk({name, ".overrun"}, 32'(overrun), 32'h0);
        chk({name, ".i_ready"}, 32'(i_ready), 32'h1);
    endtask

    // Reset pulse placed between clock edges; outputs must go to reset values at once.
    task automatic async_reset(string name);
        @(negedge clk);
        phase_p2 = 1'b0; set_any = 1'b0; i_ack = 1'b0; i_clear = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_vals(name);
        model_reset();
        #1 rst = 1'b0;
    endtask

    typedef struct {
        bit         p;
        bit         s;
        logic [7:0] e;
        bit         a;
        bit         c;
        bit         r;
        logic [7:0] q;
        bit         v;
        bit         o;
    } vec_t;

    vec_t tbl[8];

    initial begin
        //          p     s     enc    ack   clr   rdy   i_q    vld   ovr
        tbl[0] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 8'h4A, 1'b0, 1'b0, 1'b1, 8'h4A, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h4A, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 8'hC8, 1'b0, 1'b0, 1'b1, 8'hC8, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 8'hD9, 1'b1, 1'b0, 1'b1, 8'hD9, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};

        #12;
        check_reset_vals("por");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 8; i++) begin
            vec($sformatf("tbl%0d", i), tbl[i].p, tbl[i].s, tbl[i].e, tbl[i].a, tbl[i].c,
                1'b1, tbl[i].r, tbl[i].q, tbl[i].v, tbl[i].o);
        end

        // Back-to-back loads without ack, then a third that must be dropped
        vec("ld60", 1, 1, 8'h60, 0, 0, 1, 1'b1, 8'h60, 1'b1, 1'b0);
        vec("ld71", 1, 1, 8'h71, 0, 0, 1, PEND, 8'h60, 1'b1, !PEND);
        vec("ldF0", 1, 1, 8'hF0, 0, 0, 1, 1'b0, 8'h60, 1'b1, 1'b1);
        vec("idle", 0, 0, 8'h00, 0, 0, 1, 1'b0, 8'h60, 1'b1, 1'b1);
        vec("ack1", 0, 0, 8'h00, 1, 0, 1, 1'b1, PEND ? 8'h71 : 8'h60, PEND, 1'b1);
        vec("ld82", 1, 1, 8'h82, 0, 0, 1, 1'b1, PEND ? 8'h71 : 8'h82, 1'b1, 1'b1);
        vec("clr_all", 1, 1, 8'h93, 1, 1, 1, 1'b1, 8'h00, 1'b0, 1'b0);

        // Reset in the middle of FULL, then a normal capture
        vec("ld33", 1, 1, 8'h33, 0, 0, 1, 1'b1, 8'h33, 1'b1, 1'b0);
        async_reset("rst_mid");
        vec("ld5F", 1, 1, 8'h5F, 0, 0, 1, 1'b1, 8'h5F, 1'b1, 1'b0);
        vec("ack5F", 0, 0, 8'h00, 1, 0, 1, 1'b1, 8'h5F, 1'b0, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rnd_rst");
            end else begin
                vec("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    8'($urandom), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 31) == 0), 0, 0, 8'h00, 0, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
